// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC channel sequencer: drives the AVR channel request, drops settling
// samples, captures one tagged sample per channel and offers it on a valid/ready port.
module adc_scan_scheduler #(
   parameter int DISCARD  = 1,
   parameter int TIMEOUT  = 50000,
   parameter int SAMPLE_W = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [15:0]         channel_mask,
   output logic [3:0]          spi_channel,
   input  logic                new_sample,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [3:0]          sample_channel,
   output logic                result_valid,
   input  logic                result_ready,
   output logic [SAMPLE_W-1:0] result_data,
   output logic [3:0]          result_channel,
   output logic                timeout,
   output logic                busy
);

   localparam int DCW = (DISCARD < 1) ? 1 : $clog2(DISCARD + 1);
   localparam int TCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [DCW-1:0] DISC_LOAD = DCW'(DISCARD);
   localparam logic [TCW-1:0] TMO_LOAD  = TCW'(TIMEOUT - 1);
   localparam logic [3:0]     NO_CH     = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_DISCARD,
      S_WAIT,
      S_PRESENT
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            ptr_q, ptr_d;
   logic [DCW-1:0]        disc_cnt_q, disc_cnt_d;
   logic [TCW-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic [3:0]            spi_channel_q, spi_channel_d;
   logic                  result_valid_q, result_valid_d;
   logic [SAMPLE_W-1:0]   result_data_q, result_data_d;
   logic [3:0]            result_channel_q, result_channel_d;
   logic                  timeout_q, timeout_d;
   logic                  busy_q, busy_d;

   logic                  match;
   logic                  mask_any;
   logic                  expired;
   logic [3:0]            next_ch;
   logic [TCW-1:0]        tmo_dec;

   // Channel 15 is the "no sampling" code, so it is never part of the scan set.
   function automatic logic any_channel(input logic [15:0] mask);
      return |(mask & 16'h7FFF);
   endfunction

   function automatic logic [3:0] next_channel(input logic [3:0] ptr, input logic [15:0] mask);
      logic [15:0] m;
      logic [3:0]  c;
      logic [3:0]  pick;
      logic        found;
      m     = mask & 16'h7FFF;
      pick  = NO_CH;
      found = 1'b0;
      c     = (ptr >= 4'd14) ? 4'd0 : ptr + 4'd1;
      // Visiting the pointer channel last lets a lone enabled channel be reselected.
      for (int i = 0; i < 15; i++) begin
         if (!found && m[c]) begin
            pick  = c;
            found = 1'b1;
         end
         c = (c == 4'd14) ? 4'd0 : c + 4'd1;
      end
      return pick;
   endfunction

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      disc_cnt_d       = disc_cnt_q;
      tmo_cnt_d        = tmo_cnt_q;
      spi_channel_d    = spi_channel_q;
      result_valid_d   = result_valid_q;
      result_data_d    = result_data_q;
      result_channel_d = result_channel_q;
      timeout_d        = 1'b0;

      match    = new_sample && (sample_channel == spi_channel_q);
      mask_any = any_channel(channel_mask);
      next_ch  = next_channel(ptr_q, channel_mask);
      expired  = (tmo_cnt_q == '0);
      tmo_dec  = expired ? '0 : tmo_cnt_q - TCW'(1);

      case (state_q)
         S_IDLE: begin
            spi_channel_d = NO_CH;
            if (enable && mask_any) state_d = S_SELECT;
         end
         S_SELECT: begin
            if (!enable || !mask_any) begin
               state_d       = S_IDLE;
               spi_channel_d = NO_CH;
            end else begin
               spi_channel_d = next_ch;
               ptr_d         = next_ch;
               disc_cnt_d    = DISC_LOAD;
               tmo_cnt_d     = TMO_LOAD;
               state_d       = (DISCARD == 0) ? S_WAIT : S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (!enable) begin
               state_d       = S_IDLE;
               spi_channel_d = NO_CH;
            end else begin
               tmo_cnt_d = tmo_dec;
               if (match) begin
                  disc_cnt_d = disc_cnt_q - DCW'(1);
                  if (disc_cnt_q == DCW'(1)) state_d = S_WAIT;
               end else if (expired) begin
                  timeout_d = 1'b1;
                  state_d   = S_SELECT;
               end
            end
         end
         S_WAIT: begin
            if (!enable) begin
               state_d       = S_IDLE;
               spi_channel_d = NO_CH;
            end else if (match) begin
               result_data_d    = sample;
               result_channel_d = sample_channel;
               result_valid_d   = 1'b1;
               state_d          = S_PRESENT;
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = S_SELECT;
            end else begin
               tmo_cnt_d = tmo_dec;
            end
         end
         S_PRESENT: begin
            // spi_channel is left alone here so a stalled consumer also stalls the scan.
            if (result_valid_q && result_ready) begin
               result_valid_d = 1'b0;
               if (enable) begin
                  state_d = S_SELECT;
               end else begin
                  state_d       = S_IDLE;
                  spi_channel_d = NO_CH;
               end
            end
         end
         default: begin
            state_d       = S_IDLE;
            spi_channel_d = NO_CH;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         ptr_q            <= NO_CH;
         disc_cnt_q       <= '0;
         tmo_cnt_q        <= '0;
         spi_channel_q    <= NO_CH;
         result_valid_q   <= 1'b0;
         result_data_q    <= '0;
         result_channel_q <= '0;
         timeout_q        <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         ptr_q            <= ptr_d;
         disc_cnt_q       <= disc_cnt_d;
         tmo_cnt_q        <= tmo_cnt_d;
         spi_channel_q    <= spi_channel_d;
         result_valid_q   <= result_valid_d;
         result_data_q    <= result_data_d;
         result_channel_q <= result_channel_d;
         timeout_q        <= timeout_d;
         busy_q           <= busy_d;
      end
   end

   assign spi_channel    = spi_channel_q;
   assign result_valid   = result_valid_q;
   assign result_data    = result_data_q;
   assign result_channel = result_channel_q;
   assign timeout        = timeout_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler: table of scan scenarios against a simple AVR
// model, plus hand-written sequences for latency, backpressure, abort and reset cases.
module tb_adc_scan_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] channel_mask;
   logic [3:0]  spi_channel;
   logic        new_sample;
   logic [9:0]  sample;
   logic [3:0]  sample_channel;
   logic        result_valid;
   logic        result_ready;
   logic [9:0]  result_data;
   logic [3:0]  result_channel;
   logic        timeout;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic        model_on;
   logic [15:0] mute;
   int          mcnt;

   typedef struct packed {
      logic [15:0]      mask;
      logic [15:0]      mute;
      logic [3:0][3:0]  ch;
      logic [3:0]       to;
   } vec_t;

   vec_t vecs [5];

   adc_scan_scheduler #(
      .DISCARD  (1),
      .TIMEOUT  (20),
      .SAMPLE_W (10)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .channel_mask   (channel_mask),
      .spi_channel    (spi_channel),
      .new_sample     (new_sample),
      .sample         (sample),
      .sample_channel (sample_channel),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .result_data    (result_data),
      .result_channel (result_channel),
      .timeout        (timeout),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // AVR stand-in: answers the currently requested channel every third cycle.
   task automatic drive_model();
      mcnt++;
      if (model_on && spi_channel != 4'hF && !mute[spi_channel] && (mcnt % 3 == 0)) begin
         new_sample     = 1'b1;
         sample_channel = spi_channel;
         sample         = 10'h100 + {6'd0, spi_channel};
      end else begin
         new_sample = 1'b0;
      end
   endtask

   task automatic strobe(input logic [3:0] tag, input logic [9:0] val);
      new_sample     = 1'b1;
      sample_channel = tag;
      sample         = val;
      cyc();
      new_sample = 1'b0;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      enable       = 1'b0;
      new_sample   = 1'b0;
      result_ready = 1'b0;
      model_on     = 1'b0;
      mute         = 16'h0000;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic wait_spi(input logic [3:0] ch, input string name);
      int n = 0;
      while (spi_channel !== ch && n < 200) begin
         cyc();
         n++;
      end
      chk(name, spi_channel, ch);
   endtask

   initial begin
      logic [3:0] ev_ch [4];
      logic       ev_to [4];
      logic [9:0] ev_d  [4];
      int         nev;
      int         ncyc;
      int         bad;
      logic [9:0] exp_d;

      vecs[0] = '{mask: 16'h0003, mute: 16'h0000, ch: {4'd1, 4'd0, 4'd1, 4'd0}, to: 4'b0000};
      vecs[1] = '{mask: 16'h0210, mute: 16'h0200, ch: {4'd9, 4'd4, 4'd9, 4'd4}, to: 4'b1010};
      vecs[2] = '{mask: 16'h0020, mute: 16'h0000, ch: {4'd5, 4'd5, 4'd5, 4'd5}, to: 4'b0000};
      vecs[3] = '{mask: 16'hC001, mute: 16'h0000, ch: {4'd14, 4'd0, 4'd14, 4'd0}, to: 4'b0000};
      vecs[4] = '{mask: 16'h4100, mute: 16'h0000, ch: {4'd14, 4'd8, 4'd14, 4'd8}, to: 4'b0000};

      mcnt           = 0;
      channel_mask   = 16'h0000;
      sample         = '0;
      sample_channel = '0;
      do_reset();

      chk("reset spi_channel", spi_channel, 4'hF);
      chk("reset result_valid", result_valid, 1'b0);
      chk("reset result_data", result_data, 10'h000);
      chk("reset result_channel", result_channel, 4'h0);
      chk("reset timeout", timeout, 1'b0);
      chk("reset busy", busy, 1'b0);

      for (int r = 0; r < 5; r++) begin
         do_reset();
         channel_mask = vecs[r].mask;
         mute         = vecs[r].mute;
         result_ready = 1'b1;
         model_on     = 1'b1;
         enable       = 1'b1;
         for (int i = 0; i < 4; i++) begin
            ev_ch[i] = 4'hF;
            ev_to[i] = 1'bx;
            ev_d[i]  = 10'h3FF;
         end
         nev  = 0;
         ncyc = 0;
         while (nev < 4 && ncyc < 600) begin
            cyc();
            ncyc++;
            if (result_valid) begin
               ev_ch[nev] = result_channel;
               ev_to[nev] = 1'b0;
               ev_d[nev]  = result_data;
               nev++;
            end else if (timeout) begin
               ev_ch[nev] = spi_channel;
               ev_to[nev] = 1'b1;
               ev_d[nev]  = 10'h000;
               nev++;
            end
            drive_model();
         end
         chk($sformatf("vec%0d event count", r), nev, 4);
         for (int i = 0; i < 4; i++) begin
            exp_d = vecs[r].to[i] ? 10'h000 : 10'h100 + {6'd0, vecs[r].ch[i]};
            chk($sformatf("vec%0d ev%0d channel", r, i), ev_ch[i], vecs[r].ch[i]);
            chk($sformatf("vec%0d ev%0d timeout", r, i), ev_to[i], vecs[r].to[i]);
            chk($sformatf("vec%0d ev%0d data", r, i), ev_d[i], exp_d);
         end
      end

      // Timeout fires a fixed number of cycles after the channel is presented.
      do_reset();
      channel_mask = 16'h0200;
      enable       = 1'b1;
      wait_spi(4'd9, "tmo select ch9");
      ncyc = 0;
      while (!timeout && ncyc < 100) begin
         cyc();
         ncyc++;
      end
      chk("tmo latency", ncyc, 20);
      chk("tmo no result", result_valid, 1'b0);

      // Backpressure: result and channel request frozen while the consumer stalls.
      do_reset();
      channel_mask = 16'h0006;
      enable       = 1'b1;
      wait_spi(4'd1, "bp select ch1");
      strobe(4'd1, 10'h055);
      chk("bp first sample dropped", result_valid, 1'b0);
      strobe(4'd1, 10'h101);
      chk("bp capture valid", result_valid, 1'b1);
      chk("bp capture data", result_data, 10'h101);
      chk("bp capture channel", result_channel, 4'd1);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (i % 5 == 0) begin
            new_sample     = 1'b1;
            sample_channel = 4'd1;
            sample         = 10'h3FF;
         end else begin
            new_sample = 1'b0;
         end
         cyc();
         if (result_valid !== 1'b1 || result_data !== 10'h101 || result_channel !== 4'd1 ||
             spi_channel !== 4'd1 || busy !== 1'b1 || timeout !== 1'b0)
            bad++;
      end
      new_sample = 1'b0;
      chk("bp stall cycles disturbed", bad, 0);
      result_ready = 1'b1;
      cyc();
      chk("bp valid drops after accept", result_valid, 1'b0);
      result_ready = 1'b0;
      cyc();
      chk("bp scan advances", spi_channel, 4'd2);

      // Wrong tags are ignored in WAIT; enable drop aborts, re-enable resumes after it.
      do_reset();
      channel_mask = 16'h0030;
      enable       = 1'b1;
      wait_spi(4'd4, "tag select ch4");
      strobe(4'd4, 10'h011);
      strobe(4'd5, 10'h155);
      chk("tag wrong ignored", result_valid, 1'b0);
      strobe(4'd5, 10'h156);
      chk("tag wrong ignored again", result_valid, 1'b0);
      strobe(4'd4, 10'h1A4);
      chk("tag capture valid", result_valid, 1'b1);
      chk("tag capture data", result_data, 10'h1A4);
      chk("tag capture channel", result_channel, 4'd4);
      result_ready = 1'b1;
      cyc();
      result_ready = 1'b0;
      cyc();
      chk("tag next channel", spi_channel, 4'd5);
      strobe(4'd5, 10'h0AA);
      enable = 1'b0;
      cyc();
      chk("abort spi_channel", spi_channel, 4'hF);
      chk("abort busy", busy, 1'b0);
      chk("abort no result", result_valid, 1'b0);
      chk("abort no timeout", timeout, 1'b0);
      cyc();
      cyc();
      enable = 1'b1;
      cyc();
      chk("resume busy in select", busy, 1'b1);
      cyc();
      chk("resume after aborted ch", spi_channel, 4'd4);

      // Empty mask never leaves IDLE.
      do_reset();
      channel_mask = 16'h0000;
      enable       = 1'b1;
      bad          = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (spi_channel !== 4'hF || busy !== 1'b0) bad++;
      end
      chk("empty mask idle cycles", bad, 0);

      // Reset while a result is pending.
      do_reset();
      channel_mask = 16'h0002;
      enable       = 1'b1;
      wait_spi(4'd1, "rst select ch1");
      strobe(4'd1, 10'h001);
      strobe(4'd1, 10'h2C3);
      chk("rst pending valid", result_valid, 1'b1);
      rst = 1'b1;
      cyc();
      chk("rst spi_channel", spi_channel, 4'hF);
      chk("rst result_valid", result_valid, 1'b0);
      chk("rst result_data", result_data, 10'h000);
      chk("rst result_channel", result_channel, 4'h0);
      chk("rst timeout", timeout, 1'b0);
      chk("rst busy", busy, 1'b0);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Sequences the AVR's ADC channel-select bus (spi_channel) round-robin over a programmable set of analog inputs. It sits between the AVR SPI interface block and user logic. For each channel it discards settling samples, captures one valid sample with a tag, and presents it on a valid/ready result port. A per-channel timeout recovers from a stalled AVR.

Parameters:
DISCARD, 1, matching samples dropped after each channel change (mux settling); 0 means capture the first matching sample.
TIMEOUT, 50000, cycles allowed per channel from SELECT exit until capture; 1 ms at 50 MHz; must be >= 2.
SAMPLE_W, 10, ADC sample width.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
enable  in  1  scanning enabled
channel_mask  in  16  bit n enables ADC channel n; bit 15 ignored
spi_channel  out  4  channel request to AVR interface; 4'hF = no sampling
new_sample  in  1  one-cycle strobe from AVR interface
sample  in  SAMPLE_W  sample value, valid with new_sample
sample_channel  in  4  channel tag, valid with new_sample
result_valid  out  1  result held for consumer
result_ready  in  1  consumer accepts result
result_data  out  SAMPLE_W  captured sample
result_channel  out  4  channel of result_data
timeout  out  1  one-cycle pulse: channel skipped, no sample
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, spi_channel=4'hF, result_valid=0, result_data=0, result_channel=0, timeout=0, busy=0, last-channel pointer=15, counters cleared.
- Next-channel search: the lowest enabled channel in channel_mask[14:0] strictly after the pointer, wrapping 14->0. If the pointer channel is the only enabled channel, it is selected again. The mask is sampled only in IDLE and SELECT; changes elsewhere take effect at the next SELECT.
- IDLE: spi_channel=4'hF. If enable=1 and mask[14:0]!=0, go to SELECT. An empty mask keeps the block in IDLE.
- SELECT (1 cycle): compute next channel; register it into spi_channel and the pointer; load the discard counter with DISCARD and the timeout counter with TIMEOUT-1; go to DISCARD, or to WAIT if DISCARD=0. If the mask became empty, go to IDLE with spi_channel=4'hF.
- DISCARD: each new_sample with sample_channel==spi_channel decrements the discard counter. The sample that brings it to 0 moves the state to WAIT. Non-matching samples are ignored.
- WAIT: the first new_sample with a matching tag captures sample and tag into result_data/result_channel; state goes to PRESENT and result_valid=1 on the next cycle. Capture latency is 1 cycle from the strobe.
- Timeout: in DISCARD and WAIT the timeout counter decrements every cycle. If it is 0 with no matching strobe in that cycle, timeout pulses high for 1 cycle and the state goes to SELECT (channel skipped). A matching strobe in the same cycle as expiry wins: capture, no timeout.
- PRESENT: result_valid, result_data and result_channel stay stable until result_valid && result_ready. On the handshake, result_valid=0 next cycle, then go to SELECT if enable=1, else IDLE. spi_channel keeps its current channel while waiting (backpressure stalls the scan). new_sample is ignored.
- enable=0 in SELECT, DISCARD or WAIT: abort to IDLE next cycle, spi_channel=4'hF, no result, no timeout pulse. enable=0 in PRESENT: the result is still held until accepted, then IDLE.
- The pointer persists across IDLE. Re-enabling resumes after the last channel scanned; only reset returns the pointer to 15.
- rst mid-operation discards any pending result (result_valid=0 after the edge).
- Counters are wide enough for TIMEOUT and DISCARD; there is no overflow and no wrap at any count.

Test Plan:
- Mask=16'h0003, DISCARD=1, enable=1, model returns tag=ch, value=0x100+ch with ready=1 -> spi_channel sequence 0,1,0,1; results (0,0x100),(1,0x101) alternate; each first matching sample is dropped.
- Mask=16'h0210 with the model never answering channel 9, TIMEOUT=20 -> timeout pulses exactly 20 cycles after spi_channel=9; results only ever on ch4; scan order 4,9,4,9.
- result_ready held low 100 cycles after capture on ch1 -> result_valid, data and channel stable for all 100 cycles, spi_channel stays 1, extra strobes ignored; on the ready pulse the scan advances.
- Wrong-tag samples (tag=5 while spi_channel=4) in WAIT -> no capture; the next tag=4 sample is captured 1 cycle after its strobe.
- enable dropped during WAIT -> IDLE next cycle, spi_channel=4'hF, busy=0. Re-enable -> resumes at the channel after the aborted one.
- Mask=0 with enable=1 -> stays IDLE, spi_channel=4'hF. rst asserted during PRESENT -> result_valid=0 and all outputs at reset values after that edge.
